mem_arbiter: RTL and testbench

Shares the single-ported unified memory of the multi-cycle CPU between the instruction-fetch requester (IF state) and the data requester (MEM state, lw/sw). It accepts level requests, grants one port at a time with round-robin fairness, and drives the memory for a fixed access latency. It returns read data and a one-cycle `valid` to the served port. It sits between `control_unit`/datapath and the memory model, replacing direct memory wiring.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_rr2.sv | 30 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared types and constants for the unified-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   ARB_STATE_LEN / arb_state_t : arbiter FSM encoding (IDLE, ACCESS, RESP)
//   arb_port_t                  : requester ids (instruction fetch, data)
//   arb_cnt_width()             : access-counter width for a given latency
package mem_arbiter_pkg;

  localparam int ARB_STATE_LEN = 2;

  typedef enum logic [ARB_STATE_LEN-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_PORT_I = 1'b0,
    ARB_PORT_D = 1'b1
  } arb_port_t;

  // The counter only has to hold MEM_LAT-1, but never shrink below one bit
  // so that MEM_LAT = 1 still has a legal (always-zero) counter.
  function automatic int arb_cnt_width(input int lat);
    return (lat <= 1) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Purpose: 2-way round-robin picker between fetch and data requesters.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//   i_req, d_req : request levels from the two ports
//   last         : port that won the previous arbitration
//   winner       : chosen port (only meaningful when any = 1)
//   any          : at least one request is present
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_port_t last,
  output arb_port_t winner,
  output logic      any
);

  always_comb begin
    any = i_req | d_req;
    if (i_req && d_req) begin
      // Tie: the port that did not win last time goes first.
      winner = (last == ARB_PORT_D) ? ARB_PORT_I : ARB_PORT_D;
    end else if (d_req) begin
      winner = ARB_PORT_D;
    end else begin
      winner = ARB_PORT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch and data ports.
// Latency: request sampled in IDLE -> valid MEM_LAT+1 cycles later; one transaction per MEM_LAT+2 cycles.
// Backpressure: a requester holds req/addr/we/wdata until its gnt; requests seen while busy simply wait.
//   clk, rst_n                         : clock, async active-low reset
//   i_req/i_addr -> i_gnt/i_valid/i_rdata : read-only fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_valid/d_rdata : load/store port
//   mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata : memory side, rdata valid in last ACCESS cycle
//   busy                               : arbiter not in IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int               CNT_W    = arb_cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  arb_port_t         last;
  arb_port_t         winner;
  arb_port_t         port_q;
  logic              any;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              first_cyc;
  logic              last_cyc;
  logic              take;

  arb_rr2 u_rr2 (
    .i_req  (i_req),
    .d_req  (d_req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  // The counter is loaded on entry and counts down, so its load value marks
  // the first ACCESS cycle (grant) and zero marks the last (data capture).
  // With MEM_LAT = 1 both coincide.
  assign first_cyc = (cnt == CNT_LOAD);
  assign last_cyc  = (cnt == '0);
  assign take      = (state == ARB_IDLE) && any;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:   if (any) state_nxt = ARB_ACCESS;
      ARB_ACCESS: if (last_cyc) state_nxt = ARB_RESP;
      ARB_RESP:   state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  // ---------------- transaction registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= ARB_PORT_D;  // first tie after reset goes to fetch
      port_q    <= ARB_PORT_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (take) begin
        last    <= winner;
        port_q  <= winner;
        cnt     <= CNT_LOAD;
        if (winner == ARB_PORT_D) begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          wdata_q <= d_wdata;
        end else begin
          addr_q  <= i_addr;
          we_q    <= 1'b0;
          wdata_q <= '0;
        end
      end else if (state == ARB_ACCESS) begin
        if (!last_cyc) begin
          cnt <= cnt - 1'b1;
        end else if (!we_q) begin
          // Stores leave the data port's read register untouched.
          if (port_q == ARB_PORT_D) begin
            d_rdata_q <= mem_rdata;
          end else begin
            i_rdata_q <= mem_rdata;
          end
        end
      end
    end
  end

  // ---------------- outputs (state and latched registers only) ----------------
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != ARB_IDLE);
    case (state)
      ARB_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        i_gnt     = first_cyc && (port_q == ARB_PORT_I);
        d_gnt     = first_cyc && (port_q == ARB_PORT_D);
      end
      ARB_RESP: begin
        i_valid = (port_q == ARB_PORT_I);
        d_valid = (port_q == ARB_PORT_D);
      end
      default: ;
    endcase
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // main instance (MEM_LAT = 2)
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_gnt, i_valid, d_gnt, d_valid, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  // second instance (MEM_LAT = 1)
  logic        i_req1, d_req1, d_we1;
  logic [31:0] i_addr1, d_addr1, d_wdata1, mem_rdata1;
  logic        i_gnt1, i_valid1, d_gnt1, d_valid1, mem_en1, mem_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_valid(i_valid1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // memory contents: the bus-driven array is what the DUT sees; ref_mem is the
  // bench's own idea of memory, updated from the transactions it expects.
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : init_word(a);
  endfunction
  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // transaction-level reference: one transaction decided in cycle t_start
  // occupies cycles t_start+1 .. t_start+LAT+1; arbitration resumes at +LAT+2.
  int          t_start = -100;
  int          free_at = 0;
  logic        m_port  = 1'b0;   // 0 = fetch, 1 = data
  logic        m_last  = 1'b1;   // data won last -> first tie to fetch
  logic        m_we    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  // requester agents
  logic        i_granted = 1'b0, d_granted = 1'b0;
  int          rate = 0, renew = 0;
  logic        pend_i = 1'b0, pend_d = 1'b0;
  logic [31:0] pi_addr = '0, pd_addr = '0, pd_wdata = '0;
  logic        pd_we = 1'b0;

  task automatic new_i();
    i_req = 1'b1;
    i_granted = 1'b0;
    if (pend_i) begin
      i_addr = pi_addr;
      pend_i = 1'b0;
    end else begin
      i_addr = 32'($urandom_range(0, 15)) << 2;
    end
  endtask

  task automatic new_d();
    d_req = 1'b1;
    d_granted = 1'b0;
    if (pend_d) begin
      d_addr = pd_addr; d_we = pd_we; d_wdata = pd_wdata;
      pend_d = 1'b0;
    end else begin
      d_addr  = 32'($urandom_range(0, 15)) << 2;
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
    end
  endtask

  // one cycle's worth of work at the falling edge: check, memory, agents, model
  task automatic body();
    int k;
    logic [6:0] ectl;
    k = cyc - t_start;
    if (k == LAT + 1 && !m_we) begin
      if (m_port) exp_d_rdata = rd_ref(m_addr);
      else        exp_i_rdata = rd_ref(m_addr);
    end
    ectl[6] = (k == 1) && !m_port;
    ectl[5] = (k == 1) && m_port;
    ectl[4] = (k == LAT + 1) && !m_port;
    ectl[3] = (k == LAT + 1) && m_port;
    ectl[2] = (k >= 1) && (k <= LAT);
    ectl[1] = ectl[2] && m_we;
    ectl[0] = (k >= 1) && (k <= LAT + 1);
    chk("ctl{ig,dg,iv,dv,en,we,busy}", {i_gnt, d_gnt, i_valid, d_valid, mem_en, mem_we, busy}, ectl);
    if (ectl[2]) chk("mem_addr", mem_addr, m_addr);
    if (ectl[1]) chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);

    if (mem_en && mem_we) mem_model[mem_addr] = mem_wdata;
    mem_rdata = mem_en ? rd_model(mem_addr) : 32'hBAD0_BAD0;

    if (i_req && !i_granted && i_gnt) i_granted = 1'b1;
    else if (i_granted && i_valid) begin
      i_granted = 1'b0;
      if ($urandom_range(0, 99) < renew) new_i(); else i_req = 1'b0;
    end else if (!i_req && (pend_i || $urandom_range(0, 99) < rate)) new_i();

    if (d_req && !d_granted && d_gnt) d_granted = 1'b1;
    else if (d_granted && d_valid) begin
      d_granted = 1'b0;
      if ($urandom_range(0, 99) < renew) new_d(); else d_req = 1'b0;
    end else if (!d_req && (pend_d || $urandom_range(0, 99) < rate)) new_d();

    if (cyc >= free_at && (i_req || d_req)) begin
      m_port  = (i_req && d_req) ? ~m_last : d_req;
      m_last  = m_port;
      m_addr  = m_port ? d_addr : i_addr;
      m_we    = m_port & d_we;
      m_wdata = d_wdata;
      if (m_we) ref_mem[m_addr] = m_wdata;
      t_start = cyc;
      free_at = cyc + LAT + 2;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      body();
    end
  endtask

  initial begin
    int n;
    int k;
    logic [6:0] e1;
    logic [31:0] c0, c4;
    logic act;
    rst_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    i_req1 = 0; d_req1 = 0; d_we1 = 0; i_addr1 = 0; d_addr1 = 0; d_wdata1 = 0; mem_rdata1 = 0;

    #12;
    chk("reset_ctl", {i_gnt, d_gnt, i_valid, d_valid, mem_en, mem_we, busy}, 7'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_rdata", {i_rdata, d_rdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    body();

    // single fetch from 0x4
    mem_model[32'h4] = 32'h2010_0005;
    ref_mem[32'h4]   = 32'h2010_0005;
    pi_addr = 32'h4; pend_i = 1'b1;
    step(6);
    chk("fetch_data", i_rdata, 32'h2010_0005);

    // store 0xDEADBEEF to 0x40
    pd_addr = 32'h40; pd_we = 1'b1; pd_wdata = 32'hDEAD_BEEF; pend_d = 1'b1;
    step(6);
    chk("store_mem", rd_model(32'h40), 32'hDEAD_BEEF);

    // both requesting continuously: alternation
    pi_addr = 32'h8; pd_addr = 32'h40; pd_we = 1'b0; pend_i = 1'b1; pend_d = 1'b1;
    renew = 100;
    step(24);
    renew = 0;
    step(10);

    // data request arriving during a fetch ACCESS
    pi_addr = 32'hC; pend_i = 1'b1;
    step(2);
    pd_addr = 32'h10; pd_we = 1'b0; pend_d = 1'b1;
    step(10);

    // reset pulse in the middle of an ACCESS
    pi_addr = 32'h14; pd_addr = 32'h18; pd_we = 1'b0; pend_i = 1'b1; pend_d = 1'b1;
    step(1);
    n = 0;
    while (cyc != t_start + 1 && n < 10) begin
      step(1);
      n++;
    end
    chk("rst_setup_in_access", 1'(cyc == t_start + 1), 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {i_gnt, d_gnt, i_valid, d_valid, mem_en, mem_we, busy}, 7'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_rdata", {i_rdata, d_rdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t_start = -100; free_at = 0; m_last = 1'b1;
    exp_i_rdata = '0; exp_d_rdata = '0;
    i_granted = 1'b0; d_granted = 1'b0;
    body();
    step(12);

    // random traffic
    rate = 30; renew = 30;
    step(3000);
    rate = 0; renew = 0;
    step(20);
    chk("drain_reqs_low", {i_req, d_req}, 2'b00);

    // MEM_LAT = 1: back-to-back fetches at 0x0 then 0x4
    c0 = 32'h1111_0000;
    c4 = 32'h2222_0004;
    @(negedge clk);
    i_req1 = 1'b1; i_addr1 = 32'h0;
    n = cyc;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      k = cyc - n;
      act = ((k - 1) / 3) < 2;
      e1 = '0;
      if (act) begin
        e1[6] = ((k - 1) % 3) == 0;
        e1[4] = ((k - 1) % 3) == 1;
        e1[2] = ((k - 1) % 3) == 0;
        e1[0] = ((k - 1) % 3) != 2;
      end
      chk("lat1_ctl", {i_gnt1, d_gnt1, i_valid1, d_valid1, mem_en1, mem_we1, busy1}, e1);
      if (e1[2]) chk("lat1_mem_addr", mem_addr1, (k < 3) ? 32'h0 : 32'h4);
      if (e1[4]) chk("lat1_rdata", i_rdata1, (k < 3) ? c0 : c4);
      chk("lat1_d_rdata", d_rdata1, 32'd0);
      mem_rdata1 = mem_en1 ? ((mem_addr1 == 32'h4) ? c4 : c0) : 32'hBAD0_BAD0;
      if (k == 2) i_addr1 = 32'h4;
      if (k == 5) i_req1 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
